frame_overlap_buffer: RTL and testbench

- Framing stage directly upstream of the Hamming window in the MFCC front end.
- Takes a continuous audio sample stream and stores it in a circular buffer.
- Emits overlapping frames of FRAME_LEN samples, advancing HOP samples per frame, over a valid/ready stream with first/last markers.
- Absorbs input arriving during output stalls; detects and flags overrun.

---
 rtl/mfcc_pkg.sv | 19 +
 rtl/frame_overlap_buffer_if.sv | 29 ++
 rtl/frame_ring_ram.sv | 25 ++
 rtl/frame_overlap_buffer.sv | 152 +++++++++++++++
 tb/tb_frame_overlap_buffer.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mfcc_pkg.sv
// Constants and types shared by the MFCC front-end stages (framing, window, FFT).
package mfcc_pkg;

    localparam int unsigned DATA_W    = 16;
    localparam int unsigned FRAME_LEN = 256;
    localparam int unsigned HOP       = 128;

    typedef logic signed [DATA_W-1:0] q15_t;

    typedef enum logic {
        StIdle,
        StEmit
    } frame_state_e;

    function automatic int unsigned buf_depth(input int unsigned frame_len, input int unsigned hop);
        return frame_len + hop;
    endfunction

endpackage

// File: rtl/frame_overlap_buffer_if.sv
// Sample-in / frame-out stream bundle of the framing stage.
interface frame_overlap_buffer_if #(
    parameter int unsigned DATA_W = mfcc_pkg::DATA_W
) ();

    logic [DATA_W-1:0] sample_in;
    logic              sample_valid;
    logic [DATA_W-1:0] frame_data;
    logic              frame_valid;
    logic              frame_ready;
    logic              frame_first;
    logic              frame_last;
    logic [15:0]       frame_count;
    logic              overrun;
    logic              overrun_sticky;

    modport slave (
        input  sample_in, sample_valid, frame_ready,
        output frame_data, frame_valid, frame_first, frame_last, frame_count,
               overrun, overrun_sticky
    );

    modport master (
        output sample_in, sample_valid, frame_ready,
        input  frame_data, frame_valid, frame_first, frame_last, frame_count,
               overrun, overrun_sticky
    );

endinterface

// File: rtl/frame_ring_ram.sv
// Sample ring storage: one synchronous write port, one asynchronous read port.
module frame_ring_ram #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 384,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/frame_overlap_buffer.sv
// Circular sample buffer emitting overlapping FRAME_LEN-sample frames advancing by HOP.
module frame_overlap_buffer
    import mfcc_pkg::*;
#(
    parameter int unsigned DATA_W    = mfcc_pkg::DATA_W,
    parameter int unsigned FRAME_LEN = mfcc_pkg::FRAME_LEN,
    parameter int unsigned HOP       = mfcc_pkg::HOP
) (
    input logic                   clk,
    input logic                   rst,
    frame_overlap_buffer_if.slave bus
);

    localparam int unsigned BUF_DEPTH = buf_depth(FRAME_LEN, HOP);
    localparam int unsigned FILL_W    = $clog2(BUF_DEPTH + 1);
    localparam int unsigned PTR_W     = $clog2(BUF_DEPTH);
    localparam int unsigned IDX_W     = $clog2(FRAME_LEN);

    localparam logic [FILL_W-1:0] DEPTH_F  = FILL_W'(BUF_DEPTH);
    localparam logic [FILL_W-1:0] FRAME_F  = FILL_W'(FRAME_LEN);
    localparam logic [FILL_W-1:0] HOP_F    = FILL_W'(HOP);
    localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(BUF_DEPTH - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(FRAME_LEN - 1);
    localparam logic [PTR_W:0]    DEPTH_P  = (PTR_W + 1)'(BUF_DEPTH);
    localparam logic [PTR_W:0]    HOP_P    = (PTR_W + 1)'(HOP);

    frame_state_e      state_q, state_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_base_q, rd_base_d;
    logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q;
    logic              first_q, last_q;
    logic [15:0]       count_q;
    logic              overrun_q, sticky_q;

    logic              wr_en, load, complete, drop;
    logic [PTR_W:0]    addr_sum, base_sum;
    logic [PTR_W-1:0]  rd_addr;
    logic [DATA_W-1:0] rd_data;

    // Acceptance is decided on the pre-update fill, even on a frame-completion cycle.
    assign wr_en    = bus.sample_valid && (fill_q < DEPTH_F);
    assign drop     = bus.sample_valid && (fill_q == DEPTH_F);
    assign load     = (state_q == StEmit) && (!valid_q || bus.frame_ready);
    assign complete = load && (rd_idx_q == LAST_IDX);

    // Ring depth need not be a power of two, so wrap by compare-and-subtract.
    assign addr_sum = {1'b0, rd_base_q} + (PTR_W + 1)'(rd_idx_q);
    assign base_sum = {1'b0, rd_base_q} + HOP_P;
    assign rd_addr  = (addr_sum >= DEPTH_P) ? PTR_W'(addr_sum - DEPTH_P) : PTR_W'(addr_sum);

    always_comb begin
        state_d   = state_q;
        fill_d    = fill_q;
        wr_ptr_d  = wr_ptr_q;
        rd_base_d = rd_base_q;
        rd_idx_d  = rd_idx_q;
        valid_d   = valid_q;

        if (wr_en) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
            fill_d   = fill_q + 1'b1;
        end
        if (complete) begin
            fill_d    = fill_d - HOP_F;
            rd_base_d = (base_sum >= DEPTH_P) ? PTR_W'(base_sum - DEPTH_P) : PTR_W'(base_sum);
        end

        if (load) begin
            valid_d  = 1'b1;
            rd_idx_d = rd_idx_q + 1'b1;
        end else if (bus.frame_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            StIdle: begin
                if (fill_q >= FRAME_F) begin
                    state_d  = StEmit;
                    rd_idx_d = '0;
                end
            end
            StEmit: begin
                if (complete) begin
                    rd_idx_d = '0;
                    state_d  = (fill_d >= FRAME_F) ? StEmit : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            fill_q    <= '0;
            wr_ptr_q  <= '0;
            rd_base_q <= '0;
            rd_idx_q  <= '0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            first_q   <= 1'b0;
            last_q    <= 1'b0;
            count_q   <= '0;
            overrun_q <= 1'b0;
            sticky_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            fill_q    <= fill_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_base_q <= rd_base_d;
            rd_idx_q  <= rd_idx_d;
            valid_q   <= valid_d;
            overrun_q <= drop;
            if (drop) begin
                sticky_q <= 1'b1;
            end
            if (load) begin
                data_q  <= rd_data;
                first_q <= (rd_idx_q == '0);
                last_q  <= (rd_idx_q == LAST_IDX);
            end
            if (complete) begin
                count_q <= count_q + 16'd1;
            end
        end
    end

    frame_ring_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (BUF_DEPTH),
        .ADDR_W (PTR_W)
    ) u_ring (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr_q),
        .wdata (bus.sample_in),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    assign bus.frame_data     = data_q;
    assign bus.frame_valid    = valid_q;
    assign bus.frame_first    = first_q;
    assign bus.frame_last     = last_q;
    assign bus.frame_count    = count_q;
    assign bus.overrun        = overrun_q;
    assign bus.overrun_sticky = sticky_q;

endmodule

// File: tb/tb_frame_overlap_buffer.sv
// Directed bench for frame_overlap_buffer with FRAME_LEN=8, HOP=4 (ring depth 12).
module tb_frame_overlap_buffer;

    localparam int unsigned DW = 16;
    localparam int unsigned FL = 8;
    localparam int unsigned HP = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    frame_overlap_buffer_if #(.DATA_W(DW)) bus ();

    frame_overlap_buffer #(
        .DATA_W    (DW),
        .FRAME_LEN (FL),
        .HOP       (HP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [15:0] q_data[$];
    logic        q_first[$];
    logic        q_last[$];

    // Record every transfer; sampled mid-cycle, so it reflects the coming edge.
    always @(negedge clk) begin
        if (!rst && bus.frame_valid && bus.frame_ready) begin
            q_data.push_back(bus.frame_data);
            q_first.push_back(bus.frame_first);
            q_last.push_back(bus.frame_last);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        q_data.delete();
        q_first.delete();
        q_last.delete();
    endtask

    task automatic drive(input int v);
        bus.sample_in    = 16'(v);
        bus.sample_valid = 1'b1;
        step();
        bus.sample_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst              = 1'b1;
        bus.sample_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
        clear_q();
    endtask

    task automatic wait_xfers(input int n, input int budget, output bit ok);
        for (int i = 0; i < budget; i++) begin
            if (q_data.size() >= n) break;
            step();
        end
        ok = (q_data.size() >= n);
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if ({bus.frame_valid, bus.frame_first, bus.frame_last, bus.overrun,
             bus.overrun_sticky} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 00000", {bus.frame_valid, bus.frame_first,
                     bus.frame_last, bus.overrun, bus.overrun_sticky});
        end
        checks++;
        if (bus.frame_data !== 16'd0) begin
            errors++;
            $display("FAIL reset_data: got %0d want 0", bus.frame_data);
        end
        checks++;
        if (bus.frame_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d want 0", bus.frame_count);
        end
        step();
        step();
        checks++;
        if (bus.frame_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_valid: got %b want 0", bus.frame_valid);
        end
    endtask

    task automatic test_single_frame();
        bit ok;
        for (int v = 1; v <= 8; v++) drive(v);
        // Sample 8 written at edge k: nothing after k, nothing after k+1, sample 1 after k+2.
        @(negedge clk);
        checks++;
        if (bus.frame_valid !== 1'b0) begin
            errors++;
            $display("FAIL lat_k: got valid %b want 0", bus.frame_valid);
        end
        @(negedge clk);
        checks++;
        if (bus.frame_valid !== 1'b0) begin
            errors++;
            $display("FAIL lat_k1: got valid %b want 0", bus.frame_valid);
        end
        @(negedge clk);
        checks++;
        if (bus.frame_valid !== 1'b1 || bus.frame_data !== 16'd1 || bus.frame_first !== 1'b1) begin
            errors++;
            $display("FAIL lat_k2: got v%b d%0d f%b want v1 d1 f1", bus.frame_valid,
                     bus.frame_data, bus.frame_first);
        end
        step();
        wait_xfers(8, 40, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL f1_timeout: got %0d transfers want 8", q_data.size());
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (q_data.size() <= i || q_data[i] !== 16'(i + 1) || q_first[i] !== (i == 0) ||
                q_last[i] !== (i == 7)) begin
                errors++;
                $display("FAIL f1[%0d]: got %0d/%b/%b want %0d/%b/%b", i, q_data[i], q_first[i],
                         q_last[i], i + 1, i == 0, i == 7);
            end
        end
        repeat (4) step();
        checks++;
        if (q_data.size() != 8 || bus.frame_count !== 16'd1) begin
            errors++;
            $display("FAIL f1_count: got %0d xfers cnt %0d want 8 cnt 1", q_data.size(),
                     bus.frame_count);
        end
    endtask

    task automatic test_overlap();
        bit ok;
        clear_q();
        for (int v = 9; v <= 12; v++) drive(v);
        wait_xfers(8, 40, ok);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (q_data.size() <= i || q_data[i] !== 16'(i + 5) || q_first[i] !== (i == 0) ||
                q_last[i] !== (i == 7)) begin
                errors++;
                $display("FAIL f2[%0d]: got %0d/%b/%b want %0d/%b/%b", i, q_data[i], q_first[i],
                         q_last[i], i + 5, i == 0, i == 7);
            end
        end
        step();
        checks++;
        if (bus.frame_count !== 16'd2) begin
            errors++;
            $display("FAIL f2_count: got %0d want 2", bus.frame_count);
        end
        clear_q();
        for (int v = 13; v <= 16; v++) drive(v);
        wait_xfers(8, 40, ok);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (q_data.size() <= i || q_data[i] !== 16'(i + 9) || q_first[i] !== (i == 0) ||
                q_last[i] !== (i == 7)) begin
                errors++;
                $display("FAIL f3[%0d]: got %0d/%b/%b want %0d/%b/%b", i, q_data[i], q_first[i],
                         q_last[i], i + 9, i == 0, i == 7);
            end
        end
        step();
        checks++;
        if (bus.frame_count !== 16'd3) begin
            errors++;
            $display("FAIL f3_count: got %0d want 3", bus.frame_count);
        end
    endtask

    task automatic test_stall();
        logic        pv, pr;
        logic [17:0] pd;
        clear_q();
        pv = 1'b0;
        pr = 1'b1;
        pd = '0;
        for (int c = 0; c < 40; c++) begin
            bus.frame_ready = (c % 2 == 0);
            if (c < 4) begin
                bus.sample_in    = 16'(17 + c);
                bus.sample_valid = 1'b1;
            end else begin
                bus.sample_valid = 1'b0;
            end
            @(negedge clk);
            if (pv && !pr) begin
                checks++;
                if (!bus.frame_valid ||
                    {bus.frame_data, bus.frame_first, bus.frame_last} !== pd) begin
                    errors++;
                    $display("FAIL stall_hold c%0d: got v%b %h want v1 %h", c, bus.frame_valid,
                             {bus.frame_data, bus.frame_first, bus.frame_last}, pd);
                end
            end
            pv = bus.frame_valid;
            pr = bus.frame_ready;
            pd = {bus.frame_data, bus.frame_first, bus.frame_last};
            step();
        end
        bus.frame_ready  = 1'b1;
        bus.sample_valid = 1'b0;
        checks++;
        if (q_data.size() != 8) begin
            errors++;
            $display("FAIL stall_xfers: got %0d want 8", q_data.size());
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (q_data.size() <= i || q_data[i] !== 16'(i + 13) || q_first[i] !== (i == 0) ||
                q_last[i] !== (i == 7)) begin
                errors++;
                $display("FAIL stall[%0d]: got %0d/%b/%b want %0d/%b/%b", i, q_data[i],
                         q_first[i], q_last[i], i + 13, i == 0, i == 7);
            end
        end
        checks++;
        if (bus.frame_count !== 16'd4) begin
            errors++;
            $display("FAIL stall_count: got %0d want 4", bus.frame_count);
        end
    endtask

    task automatic test_overrun();
        bit ok;
        bus.frame_ready = 1'b0;
        do_reset();
        for (int v = 1; v <= 13; v++) begin
            drive(v);
            checks++;
            if (bus.overrun !== (v == 13) || bus.overrun_sticky !== (v == 13)) begin
                errors++;
                $display("FAIL ovr_s%0d: got pulse %b sticky %b want %b %b", v, bus.overrun,
                         bus.overrun_sticky, v == 13, v == 13);
            end
        end
        step();
        checks++;
        if (bus.overrun !== 1'b0 || bus.overrun_sticky !== 1'b1) begin
            errors++;
            $display("FAIL ovr_after: got pulse %b sticky %b want 0 1", bus.overrun,
                     bus.overrun_sticky);
        end
        checks++;
        if (bus.frame_valid !== 1'b1 || bus.frame_data !== 16'd1 || bus.frame_first !== 1'b1) begin
            errors++;
            $display("FAIL ovr_held: got v%b d%0d f%b want v1 d1 f1", bus.frame_valid,
                     bus.frame_data, bus.frame_first);
        end
        bus.frame_ready = 1'b1;
        wait_xfers(16, 60, ok);
        repeat (6) step();
        checks++;
        if (q_data.size() != 16) begin
            errors++;
            $display("FAIL ovr_xfers: got %0d want 16", q_data.size());
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (q_data.size() <= i || q_data[i] !== 16'((i < 8) ? i + 1 : i - 3) ||
                q_first[i] !== (i % 8 == 0) || q_last[i] !== (i % 8 == 7)) begin
                errors++;
                $display("FAIL ovr[%0d]: got %0d/%b/%b want %0d/%b/%b", i, q_data[i], q_first[i],
                         q_last[i], (i < 8) ? i + 1 : i - 3, i % 8 == 0, i % 8 == 7);
            end
        end
        checks++;
        if (bus.frame_count !== 16'd2 || bus.overrun_sticky !== 1'b1) begin
            errors++;
            $display("FAIL ovr_end: got cnt %0d sticky %b want 2 1", bus.frame_count,
                     bus.overrun_sticky);
        end
    endtask

    task automatic test_completion_write();
        int  sched[17] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 0, 0, 0, 0, 0, 12};
        bit  seen;
        int  xf;
        seen = 1'b0;
        xf   = 0;
        bus.frame_ready = 1'b1;
        do_reset();
        // Sample 12 lands on the edge that loads sample 8 of the first frame (fill 11).
        for (int i = 0; i < 40; i++) begin
            if (i < 17 && sched[i] != 0) begin
                bus.sample_in    = 16'(sched[i]);
                bus.sample_valid = 1'b1;
            end else begin
                bus.sample_valid = 1'b0;
            end
            @(negedge clk);
            if (bus.frame_valid) seen = 1'b1;
            if (seen && xf < 16) begin
                checks++;
                if (bus.frame_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL bubble c%0d: got valid %b want 1 after %0d xfers", i,
                             bus.frame_valid, xf);
                end
            end
            if (bus.frame_valid && bus.frame_ready) xf++;
            step();
        end
        bus.sample_valid = 1'b0;
        checks++;
        if (q_data.size() != 16 || bus.overrun_sticky !== 1'b0) begin
            errors++;
            $display("FAIL cw_xfers: got %0d sticky %b want 16 0", q_data.size(),
                     bus.overrun_sticky);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (q_data.size() <= i || q_data[i] !== 16'((i < 8) ? i + 1 : i - 3) ||
                q_first[i] !== (i % 8 == 0) || q_last[i] !== (i % 8 == 7)) begin
                errors++;
                $display("FAIL cw[%0d]: got %0d/%b/%b want %0d/%b/%b", i, q_data[i], q_first[i],
                         q_last[i], (i < 8) ? i + 1 : i - 3, i % 8 == 0, i % 8 == 7);
            end
        end
        checks++;
        if (bus.frame_count !== 16'd2) begin
            errors++;
            $display("FAIL cw_count: got %0d want 2", bus.frame_count);
        end
    endtask

    task automatic test_mid_frame_reset();
        bit ok;
        bus.frame_ready = 1'b0;
        do_reset();
        for (int v = 1; v <= 13; v++) drive(v);
        bus.frame_ready = 1'b1;
        // Frame 1..8 completes, then three samples (5,6,7) of the second frame go out.
        wait_xfers(11, 60, ok);
        checks++;
        if (!ok || bus.frame_count !== 16'd1 || bus.overrun_sticky !== 1'b1) begin
            errors++;
            $display("FAIL mr_pre: got xfers %0d cnt %0d sticky %b want 11 1 1", q_data.size(),
                     bus.frame_count, bus.overrun_sticky);
        end
        rst = 1'b1;
        step();
        checks++;
        if (bus.frame_valid !== 1'b0 || bus.frame_count !== 16'd0 ||
            bus.overrun_sticky !== 1'b0 || bus.overrun !== 1'b0) begin
            errors++;
            $display("FAIL mr_rst: got v%b cnt %0d sticky %b ovr %b want 0 0 0 0",
                     bus.frame_valid, bus.frame_count, bus.overrun_sticky, bus.overrun);
        end
        rst = 1'b0;
        clear_q();
        repeat (4) step();
        checks++;
        if (bus.frame_valid !== 1'b0 || q_data.size() != 0) begin
            errors++;
            $display("FAIL mr_idle: got v%b xfers %0d want 0 0", bus.frame_valid, q_data.size());
        end
        for (int v = 21; v <= 28; v++) drive(v);
        wait_xfers(8, 40, ok);
        repeat (4) step();
        checks++;
        if (q_data.size() != 8 || bus.frame_count !== 16'd1) begin
            errors++;
            $display("FAIL mr_post: got xfers %0d cnt %0d want 8 1", q_data.size(),
                     bus.frame_count);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (q_data.size() <= i || q_data[i] !== 16'(i + 21) || q_first[i] !== (i == 0) ||
                q_last[i] !== (i == 7)) begin
                errors++;
                $display("FAIL mr[%0d]: got %0d/%b/%b want %0d/%b/%b", i, q_data[i], q_first[i],
                         q_last[i], i + 21, i == 0, i == 7);
            end
        end
    endtask

    initial begin
        bus.sample_in    = '0;
        bus.sample_valid = 1'b0;
        bus.frame_ready  = 1'b1;
        test_reset();
        test_single_frame();
        test_overlap();
        test_stall();
        test_overrun();
        test_completion_write();
        test_mid_frame_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
